// File: rtl/reconfig_adder_sched_pkg.sv
// reconfig_adder_sched_pkg
// Shared types and constants for the adder scheduler slice.
// Contents:
//   W          operand width (result is W+1 bits)
//   NREQ       number of requesters sharing the adder
//   SchedState scheduler FSM states (IDLE, EXEC, RESP)
//   CfgSel     operand-select encodings driven on cfg_sel
//   grantToIdx one-hot grant to requester index helper
package reconfig_adder_sched_pkg;

    localparam int W    = 8;
    localparam int NREQ = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } SchedState;

    typedef enum logic [1:0] {
        SEL_A0   = 2'd0,
        SEL_A1   = 2'd1,
        SEL_A2   = 2'd2,
        SEL_ZERO = 2'd3
    } CfgSel;

    // Converts a one-hot (or zero) grant vector into the requester index.
    // A zero vector maps to index 0; callers only use the result when a
    // grant is actually present.
    function automatic logic [1:0] grantToIdx(input logic [NREQ-1:0] grant);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                idx = 2'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/reconfig_adder_sched_if.sv
// reconfig_adder_sched_if
// Bundles the requester and response ports of the adder scheduler.
// Signals:
//   req_valid  [NREQ]      per-requester request valid
//   req_ready  [NREQ]      per-requester accept (one-hot or zero)
//   req_a      [NREQ*W]    operand A, requester i at [i*W +: W]
//   req_b      [NREQ*W]    operand B, same packing
//   rsp_valid              result valid
//   rsp_ready              downstream accepts result
//   rsp_sum    [W+1]       registered b + a
//   rsp_id     [2]         owner of rsp_sum
//   cfg_sel    [2]         datapath operand select (3 = zero operand)
//   busy                   scheduler in EXEC or RESP
// Modports: master = requesters/consumer side, slave = scheduler side.
interface reconfig_adder_sched_if;
    import reconfig_adder_sched_pkg::*;

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W:0]        rsp_sum;
    logic [1:0]        rsp_id;
    logic [1:0]        cfg_sel;
    logic              busy;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_sum, rsp_id, cfg_sel, busy
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_sum, rsp_id, cfg_sel, busy
    );

endinterface

// File: rtl/reconfig_adder_sched_rr_arbiter3.sv
// rr_arbiter3
// Three-input arbiter for the adder scheduler.
// Default build: round-robin, the search starts one past the last accepted
// requester; the pointer moves only when the grant is actually accepted.
// With RECONFIG_SCHED_FIXED_PRIO_EN defined: fixed priority 0 > 1 > 2 and
// no pointer state.
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset
//   i_req     [NREQ] request vector
//   i_accept  grant was taken this cycle (advance pointer)
//   o_grant   [NREQ] one-hot grant, zero when no request
module rr_arbiter3
    import reconfig_adder_sched_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    input  logic            i_accept,
    output logic [NREQ-1:0] o_grant
);

`ifdef RECONFIG_SCHED_FIXED_PRIO_EN

    // Clock, reset and accept have no role without a pointer.
    logic w_unused;
    assign w_unused = clk ^ rst ^ i_accept;

    // Lowest index always wins.
    always_comb begin
        o_grant = '0;
        if (i_req[0]) begin
            o_grant = 3'b001;
        end else if (i_req[1]) begin
            o_grant = 3'b010;
        end else if (i_req[2]) begin
            o_grant = 3'b100;
        end
    end

`else

    logic [1:0] r_lastGrant;

    // Priority order rotates so that the requester after the last winner
    // is searched first; the reset value 2 makes requester 0 win first.
    always_comb begin
        o_grant = '0;
        case (r_lastGrant)
            2'd0: begin
                if      (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
            end
            2'd1: begin
                if      (i_req[2]) o_grant = 3'b100;
                else if (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
            end
            default: begin
                if      (i_req[0]) o_grant = 3'b001;
                else if (i_req[1]) o_grant = 3'b010;
                else if (i_req[2]) o_grant = 3'b100;
            end
        endcase
    end

    // The pointer only remembers grants that turned into a handshake, so a
    // grant offered while nothing is taken does not skew fairness.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lastGrant <= 2'd2;
        end else if (i_accept) begin
            r_lastGrant <= grantToIdx(o_grant);
        end
    end

`endif

endmodule

// File: rtl/reconfig_adder_sched.sv
// reconfig_adder_sched
// Shares one W-bit adder (sum = b + selected operand, W+1-bit result)
// among NREQ requesters. IDLE arbitrates and latches the winner's operands,
// EXEC registers the sum, RESP presents it on a valid/ready port.
// Configuration macro: RECONFIG_SCHED_FIXED_PRIO_EN selects fixed priority
// arbitration (see rr_arbiter3); undefined gives round-robin.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   reconfig_adder_sched_if.slave (requests, response, cfg_sel, busy)
module reconfig_adder_sched
    import reconfig_adder_sched_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    reconfig_adder_sched_if.slave  bus
);

    SchedState       r_state;
    SchedState       w_nextState;
    logic [NREQ-1:0] w_grant;
    logic            w_accept;
    logic [1:0]      w_winIdx;
    logic [NREQ-1:0] w_reqReady;
    logic            w_busy;

    logic [W-1:0]    r_opA;
    logic [W-1:0]    r_opB;
    logic [W-1:0]    w_selOperand;
    logic [1:0]      r_winId;
    CfgSel           r_cfgSel;
    logic [W:0]      r_sum;
    logic [1:0]      r_rspId;
    logic            r_rspValid;

    rr_arbiter3 u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_req    (bus.req_valid),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    // The grant is a subset of req_valid, so any grant offered in IDLE is a
    // completed handshake.
    assign w_accept = (r_state == IDLE) && (|w_grant);
    assign w_winIdx = grantToIdx(w_grant);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: EXEC always lasts one cycle, RESP waits for the
    // consumer.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_nextState = EXEC;
            EXEC:    w_nextState = RESP;
            RESP:    if (bus.rsp_ready) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Output logic: requests are only offered a grant while idle, which is
    // what keeps a pending result from being overtaken.
    always_comb begin
        w_reqReady = '0;
        w_busy     = 1'b0;
        case (r_state)
            IDLE:    w_reqReady = w_grant;
            EXEC:    w_busy     = 1'b1;
            RESP:    w_busy     = 1'b1;
            default: w_busy     = 1'b0;
        endcase
    end

    // Operand select of the shared adder: the zero operand is used whenever
    // no requester owns the datapath.
    always_comb begin
        w_selOperand = r_opA;
        if (r_cfgSel == SEL_ZERO) begin
            w_selOperand = '0;
        end
    end

    // Datapath and response registers. The operands are captured at the
    // handshake so requesters may change them right after being accepted;
    // the result stays frozen in RESP until the consumer takes it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opA      <= '0;
            r_opB      <= '0;
            r_winId    <= 2'd0;
            r_cfgSel   <= SEL_ZERO;
            r_sum      <= '0;
            r_rspId    <= 2'd0;
            r_rspValid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_opA    <= bus.req_a[w_winIdx*W +: W];
                        r_opB    <= bus.req_b[w_winIdx*W +: W];
                        r_winId  <= w_winIdx;
                        r_cfgSel <= CfgSel'(w_winIdx);
                    end
                end
                EXEC: begin
                    r_sum      <= {1'b0, w_selOperand} + {1'b0, r_opB};
                    r_rspId    <= r_winId;
                    r_rspValid <= 1'b1;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        r_rspValid <= 1'b0;
                        r_cfgSel   <= SEL_ZERO;
                    end
                end
                default: begin
                    r_rspValid <= 1'b0;
                    r_cfgSel   <= SEL_ZERO;
                end
            endcase
        end
    end

    assign bus.req_ready = w_reqReady;
    assign bus.busy      = w_busy;
    assign bus.rsp_valid = r_rspValid;
    assign bus.rsp_sum   = r_sum;
    assign bus.rsp_id    = r_rspId;
    assign bus.cfg_sel   = r_cfgSel;

endmodule

// File: doc/reconfig_adder_sched.md
# reconfig_adder_sched

Scheduler that shares one reconfigurable 8-bit adder datapath (sum = b + selected operand, 9-bit result) among three requesters. It arbitrates requests and latches the winner's operands. It drives the 2-bit operand-select configuration and computes the sum in a registered execute stage. It returns the result with the winner's ID over a valid/ready response port. It sits between the requester ports and downstream consumers of the 9-bit sums.

## Interface
- W, 8, operand width; result width W+1.
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- req_valid  input  3  per-requester request valid.
- req_ready  output  3  per-requester accept, one-hot or zero.
- req_a  input  3*W  operand A; requester i at bits [i*W +: W].
- req_b  input  3*W  operand B; same packing.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  downstream accepts result.
- rsp_sum  output  W+1  registered b + a, carry in bit W.
- rsp_id  output  2  index of the requester that owns rsp_sum.
- cfg_sel  output  2  datapath operand select: 0/1/2 = requester 0/1/2; 3 = zero operand (idle).
- busy  output  1  high in EXEC or RESP.

## Operation
- FSM states:
  - IDLE: req_ready is the one-hot grant when any req_valid is high; otherwise 0. A handshake (valid & ready) latches a, b and id, sets cfg_sel=id, then goes to EXEC. With no request, stays in IDLE and cfg_sel=3.
  - EXEC: one cycle. Registers rsp_sum = {1'b0,a} + {1'b0,b}, sets rsp_id, then goes to RESP.
  - RESP: rsp_valid=1. On rsp_ready, goes to IDLE and cfg_sel returns to 3. Otherwise holds, with rsp_sum and rsp_id stable.
- Arbitration: round-robin. Search starts at last_grant+1 mod 3. last_grant updates only on a request handshake.
- req_ready is 0 in EXEC and RESP. No request is accepted while a result is pending.
- Arithmetic: full W+1-bit unsigned add, carry-in 0, no overflow or wrap. 8'hFF+8'hFF = 9'h1FE.
- Protocol rule: a requester holds req_valid and its operands stable until req_ready. The block does not check this.
- Reset values: state=IDLE, last_grant=2 (requester 0 wins first), cfg_sel=3, rsp_valid=0, rsp_sum=0, rsp_id=0, req_ready=0, busy=0.
- Reset mid-operation (EXEC or RESP): the pending result is discarded and all registers return to reset values immediately.

## Timing
- Accept at edge T. EXEC during cycle T+1. rsp_valid is high from cycle T+2.
- Latency is 2 cycles from accept to rsp_valid.
- Best-case throughput is one result per 3 cycles (IDLE, EXEC, RESP with rsp_ready=1).
- req_ready is combinational from req_valid and state, with no other input dependency.
- rsp_valid, rsp_sum, rsp_id and cfg_sel are registered outputs.
- Simultaneous rsp_ready and new req_valid in RESP: the result drains, and the new request is accepted at the earliest in the following IDLE cycle.

## Configuration
- RECONFIG_SCHED_FIXED_PRIO_EN defined: fixed priority, requester 0 > 1 > 2. last_grant is unused.
- Not defined: round-robin as specified above.

## Structure
- Shared package holds:
  - the state enum (IDLE, EXEC, RESP);
  - the cfg_sel encodings (SEL_A0=0, SEL_A1=1, SEL_A2=2, SEL_ZERO=3);
  - the requester count constant NREQ=3.
- One sub-module, rr_arbiter3: a 3-input grant with pointer update on accept. It contains the fixed-priority variant under the macro.

## Test plan
- Single request on requester 0, a=8'hFF, b=8'h01, rsp_ready=1 -> req_ready=3'b001 in the accept cycle; rsp_valid 2 cycles later; rsp_sum=9'h100, rsp_id=0, cfg_sel=0 during EXEC.
- All three req_valid held, rsp_ready=1 -> grant order 0,1,2,0, with a new result every 3 cycles.
- a=8'h80, b=8'h80 -> rsp_sum=9'h100. a=0, b=0 -> rsp_sum=0. a=8'hFF, b=8'hFF -> rsp_sum=9'h1FE.
- rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_sum and rsp_id stable; req_ready=0; busy=1. rsp_ready=1 -> IDLE next cycle.
- rst asserted during EXEC -> all outputs at reset values immediately and no response is issued. Requests 1 and 2 then valid -> requester 0 priority pointer restored, so 1 is granted before 2.
- Requesters 0 and 2 continuously valid -> with RECONFIG_SCHED_FIXED_PRIO_EN only 0 is served; without it, grants alternate 0,2,0,2.
